// File: rtl/equiv_sweep_checker.sv
// Sweeps every x/y/z input combination through an external two-output expression unit.
// Records both truth tables, counts vectors where s1 != s2 and flags the first failing vector.
module equiv_sweep_checker #(
    parameter int N_IN  = 3,
    parameter int CNT_W = N_IN + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 x,
    output logic                 y,
    output logic                 z,
    input  logic                 s1,
    input  logic                 s2,
    output logic                 busy,
    output logic                 done,
    output logic                 equal,
    output logic [CNT_W-1:0]     mismatch_cnt,
    output logic [N_IN-1:0]      first_bad,
    output logic                 bad_valid,
    output logic [2**N_IN-1:0]   sig1,
    output logic [2**N_IN-1:0]   sig2
);

    typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

    localparam logic [N_IN-1:0]  LAST_VEC = '1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(2**N_IN);

    state_t          state;
    state_t          state_next;
    logic [N_IN-1:0] vec;
    logic            start_sweep;
    logic            last_vec;
    logic            mismatch;

    assign x = vec[2];
    assign y = vec[1];
    assign z = vec[0];

    assign busy     = (state == SWEEP);
    assign done     = (state == DONE);
    assign equal    = done && (mismatch_cnt == '0);
    assign last_vec = (vec == LAST_VEC);
    assign mismatch = (s1 != s2);

    // Start is only honoured outside SWEEP, so a stray pulse mid-sweep never disturbs timing.
    always_comb begin
        state_next  = state;
        start_sweep = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_next  = SWEEP;
                    start_sweep = 1'b1;
                end
            end
            SWEEP: begin
                if (last_vec) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            vec          <= '0;
            mismatch_cnt <= '0;
            first_bad    <= '0;
            bad_valid    <= 1'b0;
            sig1         <= '0;
            sig2         <= '0;
        end else begin
            state <= state_next;
            if (start_sweep) begin
                vec          <= '0;
                mismatch_cnt <= '0;
                first_bad    <= '0;
                bad_valid    <= 1'b0;
                sig1         <= '0;
                sig2         <= '0;
            end else if (state == SWEEP) begin
                // The current vector has been on x/y/z for a full period, so s1/s2 are settled here.
                sig1[vec] <= s1;
                sig2[vec] <= s2;
                if (mismatch) begin
                    if (mismatch_cnt != CNT_MAX) begin
                        mismatch_cnt <= mismatch_cnt + CNT_W'(1);
                    end
                    if (!bad_valid) begin
                        first_bad <= vec;
                        bad_valid <= 1'b1;
                    end
                end
                if (!last_vec) begin
                    vec <= vec + N_IN'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_equiv_sweep_checker.sv
// Directed bench for equiv_sweep_checker, with a behavioural expression unit whose fault mode
// is selected by the bench.
module tb_equiv_sweep_checker;

    logic       clk;
    logic       rst;
    logic       start;
    logic       x, y, z;
    logic       s1, s2;
    logic       busy, done, equal, bad_valid;
    logic [3:0] mismatch_cnt;
    logic [2:0] first_bad;
    logic [7:0] sig1, sig2;

    int mode;
    int checkCount;
    int failCount;
    int cycles;

    equiv_sweep_checker #(.N_IN(3), .CNT_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .x            (x),
        .y            (y),
        .z            (z),
        .s1           (s1),
        .s2           (s2),
        .busy         (busy),
        .done         (done),
        .equal        (equal),
        .mismatch_cnt (mismatch_cnt),
        .first_bad    (first_bad),
        .bad_valid    (bad_valid),
        .sig1         (sig1),
        .sig2         (sig2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Mode 0: correct unit, mode 1: s2 = x fault, mode 2: outputs tied s1=1, s2=0.
    always_comb begin
        s1 = x & ~(~x | y);
        s2 = x & ~y;
        if (mode == 1) begin
            s2 = x;
        end else if (mode == 2) begin
            s1 = 1'b1;
            s2 = 1'b0;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Drive start for one clock edge, then settle 1 time unit past the edge before returning.
    task automatic applyStimulus(input logic st);
        start = st;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Tick until done, counting edges; the count continues from the edges already spent.
    task automatic runToDone(input int already, output int total);
        total = already;
        while (!done && total < 40) begin
            applyStimulus(1'b0);
            total++;
        end
        if (!done) begin
            checkOutput("done_timeout", 32'(done), 32'd1);
        end
    endtask

    task automatic checkResults(input string tag, input logic eq, input logic [3:0] cnt,
                                input logic [2:0] fb, input logic bv, input logic [7:0] g1,
                                input logic [7:0] g2);
        checkOutput({tag, "_done"}, 32'(done), 32'd1);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_equal"}, 32'(equal), 32'(eq));
        checkOutput({tag, "_cnt"}, 32'(mismatch_cnt), 32'(cnt));
        checkOutput({tag, "_first_bad"}, 32'(first_bad), 32'(fb));
        checkOutput({tag, "_bad_valid"}, 32'(bad_valid), 32'(bv));
        checkOutput({tag, "_sig1"}, 32'(sig1), 32'(g1));
        checkOutput({tag, "_sig2"}, 32'(sig2), 32'(g2));
    endtask

    task automatic checkCleared(input string tag);
        checkOutput({tag, "_xyz"}, 32'({x, y, z}), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_done"}, 32'(done), 32'd0);
        checkOutput({tag, "_equal"}, 32'(equal), 32'd0);
        checkOutput({tag, "_cnt"}, 32'(mismatch_cnt), 32'd0);
        checkOutput({tag, "_first_bad"}, 32'(first_bad), 32'd0);
        checkOutput({tag, "_bad_valid"}, 32'(bad_valid), 32'd0);
        checkOutput({tag, "_sig1"}, 32'(sig1), 32'd0);
        checkOutput({tag, "_sig2"}, 32'(sig2), 32'd0);
    endtask

    initial begin
        checkCount = 0;
        failCount  = 0;
        mode       = 0;
        start      = 1'b0;
        rst        = 1'b1;
        @(posedge clk);
        applyStimulus(1'b0);
        rst = 1'b0;
        checkCleared("reset");

        // Idle with no start: everything holds.
        applyStimulus(1'b0);
        applyStimulus(1'b0);
        checkCleared("idle_hold");

        // Correct unit.
        mode = 0;
        applyStimulus(1'b1);
        checkOutput("t1_busy", 32'(busy), 32'd1);
        checkOutput("t1_vec0", 32'({x, y, z}), 32'd0);
        applyStimulus(1'b0);
        checkOutput("t1_vec1", 32'({x, y, z}), 32'd1);
        runToDone(1, cycles);
        checkOutput("t1_latency", 32'(cycles), 32'd8);
        checkOutput("t1_vec_hold", 32'({x, y, z}), 32'd7);
        checkResults("t1", 1'b1, 4'd0, 3'd0, 1'b0, 8'h30, 8'h30);
        applyStimulus(1'b0);
        applyStimulus(1'b0);
        checkResults("t1_hold", 1'b1, 4'd0, 3'd0, 1'b0, 8'h30, 8'h30);

        // s2 = x fault, launched straight from DONE.
        mode = 1;
        applyStimulus(1'b1);
        runToDone(0, cycles);
        checkOutput("t2_latency", 32'(cycles), 32'd8);
        checkResults("t2", 1'b0, 4'd2, 3'd6, 1'b1, 8'h30, 8'hF0);

        // Every vector mismatches: counter reaches its top value.
        mode = 2;
        applyStimulus(1'b1);
        runToDone(0, cycles);
        checkResults("t3", 1'b0, 4'd8, 3'd0, 1'b1, 8'hFF, 8'h00);

        // start pulsed at vec=3 mid-sweep is ignored.
        mode = 0;
        applyStimulus(1'b1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0);
        end
        checkOutput("t4_vec3", 32'({x, y, z}), 32'd3);
        applyStimulus(1'b1);
        checkOutput("t4_vec4", 32'({x, y, z}), 32'd4);
        checkOutput("t4_busy", 32'(busy), 32'd1);
        runToDone(4, cycles);
        checkOutput("t4_latency", 32'(cycles), 32'd8);
        checkResults("t4", 1'b1, 4'd0, 3'd0, 1'b0, 8'h30, 8'h30);

        // Reset mid-sweep at vec=4 with a fault present, then a clean sweep.
        mode = 2;
        applyStimulus(1'b1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0);
        end
        checkOutput("t5_vec4", 32'({x, y, z}), 32'd4);
        rst   = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        start = 1'b0;
        checkCleared("t5_reset");
        mode = 0;
        applyStimulus(1'b1);
        runToDone(0, cycles);
        checkOutput("t5_latency", 32'(cycles), 32'd8);
        checkResults("t5", 1'b1, 4'd0, 3'd0, 1'b0, 8'h30, 8'h30);

        // DONE with fault, then fix and restart back-to-back.
        mode = 1;
        applyStimulus(1'b1);
        runToDone(0, cycles);
        checkResults("t6_fault", 1'b0, 4'd2, 3'd6, 1'b1, 8'h30, 8'hF0);
        mode = 0;
        applyStimulus(1'b1);
        checkOutput("t6_busy", 32'(busy), 32'd1);
        checkOutput("t6_done", 32'(done), 32'd0);
        checkOutput("t6_cnt_clr", 32'(mismatch_cnt), 32'd0);
        checkOutput("t6_bv_clr", 32'(bad_valid), 32'd0);
        checkOutput("t6_sig2_clr", 32'(sig2), 32'd0);
        runToDone(0, cycles);
        checkOutput("t6_latency", 32'(cycles), 32'd8);
        checkResults("t6", 1'b1, 4'd0, 3'd0, 1'b0, 8'h30, 8'h30);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/equiv_sweep_checker.md
Name: equiv_sweep_checker

Overview:
Downstream checking stage for the two-output boolean-expression unit (unsimplified s1, simplified s2 over inputs x, y, z).
- Sweeps all 2^N_IN input combinations, driving them onto x/y/z.
- Samples s1/s2 each cycle, records both truth-table signatures and counts mismatches.
- Reports the first failing vector and an overall equivalence verdict.
- Replaces the hand-written $monitor sweep with a synthesizable, self-checking sequencer.

Parameters:
- N_IN, 3, number of boolean inputs; the sweep covers 2^N_IN vectors (N_IN = 3 for x, y, z).
- CNT_W, N_IN+1, mismatch counter width; must hold the value 2^N_IN.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a sweep; honoured only in IDLE or DONE.
- x  output  1  stimulus bit, equal to vec[2] (MSB).
- y  output  1  stimulus bit, equal to vec[1].
- z  output  1  stimulus bit, equal to vec[0] (LSB).
- s1  input  1  unsimplified result from the expression unit, combinational in x, y, z.
- s2  input  1  simplified result from the expression unit, combinational in x, y, z.
- busy  output  1  high while in SWEEP.
- done  output  1  high while in DONE.
- equal  output  1  valid while done=1; 1 when mismatch_cnt==0.
- mismatch_cnt  output  CNT_W  number of vectors with s1!=s2.
- first_bad  output  N_IN  first vector index with s1!=s2.
- bad_valid  output  1  first_bad holds a captured value.
- sig1  output  2^N_IN  s1 truth table; bit k = s1 at vec=k.
- sig2  output  2^N_IN  s2 truth table; bit k = s2 at vec=k.

Behaviour:
- Reset (rst=1 at a clk edge, from any state, including mid-sweep):
  - state goes to IDLE.
  - vec=0, so x=y=z=0.
  - busy=0, done=0, equal=0, mismatch_cnt=0, first_bad=0, bad_valid=0, sig1=0, sig2=0.
  - rst has priority over start.
- FSM states: IDLE, SWEEP, DONE.
- IDLE:
  - start=1 at an edge: go to SWEEP.
  - On that same edge: vec<=0; clear mismatch_cnt, bad_valid, first_bad, sig1, sig2.
- SWEEP, every edge with vec=k:
  - sig1[k]<=s1 and sig2[k]<=s2.
  - If s1!=s2: mismatch_cnt increments. If bad_valid=0, also set first_bad<=k and bad_valid<=1.
  - If k<2^N_IN-1: vec<=k+1.
  - Else: go to DONE; vec stays at 2^N_IN-1 and does not wrap.
  - start is ignored in SWEEP.
- DONE:
  - Outputs hold.
  - equal = (mismatch_cnt==0).
  - start=1 clears results and re-enters SWEEP exactly as from IDLE, giving back-to-back sweeps with no IDLE cycle.
- Stimulus and sampling:
  - x/y/z come straight from the vec register.
  - s1/s2 are sampled at the edge ending the cycle in which vec=k; the expression unit therefore has one full clock period to settle.
- Latency:
  - start sampled at edge E0.
  - Vectors 0..2^N_IN-1 sampled at edges E1..E(2^N_IN).
  - done=1 after E(2^N_IN), i.e. 8 cycles after the start edge when N_IN=3.
- Arithmetic:
  - mismatch_cnt saturates at 2^N_IN and never wraps.
  - vec is an N_IN-bit unsigned value.
- Idle behaviour: busy, done and all results hold unchanged while no start arrives.

Test Plan:
- Connect a correct expression unit (s1 = x·(x'+y)', s2 = x·y'), pulse start -> done after 8 cycles, equal=1, mismatch_cnt=0, sig1=sig2=8'h30, bad_valid=0.
- Fault injection with s2 = x -> sig2=8'hF0, mismatch_cnt=2, first_bad=3'd6, bad_valid=1, equal=0.
- Tie s1=1, s2=0 -> mismatch_cnt=8 (saturation boundary), first_bad=0, sig1=8'hFF, sig2=8'h00.
- Pulse start again at vec=3 during a sweep -> ignored; sweep ends at the original time with identical results.
- Assert rst for one cycle at vec=4 -> next cycle IDLE, x=y=z=0, all outputs 0. A new start then yields full correct results.
- From DONE with a fault present, fix the fault and pulse start -> busy=1 the next cycle, results cleared. After 8 cycles equal=1 and sig1=sig2=8'h30.
